spi_flash_arbiter: RTL and testbench

- Owns the shared SPI configuration-flash pins (cs/sck/mosi/miso) and shares them between two requesters: master 0 is the bootloader SPI bridge, master 1 is a secondary reader such as a user-image/metadata fetcher.
- After reset it sends the flash a release-from-deep-power-down command (0xAB) and waits the wake time before granting anyone.
- It then arbitrates round-robin at transaction granularity. While a master holds the grant, its SPI signals pass straight through to the pins.
- Sits between the bootloader core and the flash pin drivers in the 12 MHz `clk` domain.

---
 rtl/spi_flash_arbiter_if.sv | 29 ++
 rtl/spi_flash_arbiter.sv | 147 ++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_arbiter_if.sv
// Signal bundle between the two SPI requesters, the arbiter and the flash pins.
// The arbiter connects through the slave modport; the requester/flash side uses master.
interface spi_flash_arbiter_if;
    logic m0_req;
    logic m1_req;
    logic m0_gnt;
    logic m1_gnt;
    logic m0_cs;
    logic m1_cs;
    logic m0_sck;
    logic m1_sck;
    logic m0_mosi;
    logic m1_mosi;
    logic m_miso;
    logic spi_cs;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;

    modport slave (
        input  m0_req, m1_req, m0_cs, m1_cs, m0_sck, m1_sck, m0_mosi, m1_mosi, spi_miso,
        output m0_gnt, m1_gnt, m_miso, spi_cs, spi_sck, spi_mosi
    );

    modport master (
        output m0_req, m1_req, m0_cs, m1_cs, m0_sck, m1_sck, m0_mosi, m1_mosi, spi_miso,
        input  m0_gnt, m1_gnt, m_miso, spi_cs, spi_sck, spi_mosi
    );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Shares the SPI config-flash pins between two masters: wakes the flash with 0xAB, then
// round-robin grants per transaction. Define SPI_ARB_TIMEOUT_EN for the grant watchdog.
module spi_flash_arbiter #(
    parameter int WAKE_CYCLES    = 40,
    parameter int CS_GAP         = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spi_flash_arbiter_if.slave   bus,
    output logic                 ready,
    output logic                 timeout
);
    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        GRANT0,
        GRANT1,
        GAP
    } state_t;

    localparam logic [7:0] WAKE_OPCODE = 8'hAB;

    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255 || CS_GAP < 1 || CS_GAP > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("spi_flash_arbiter: parameter out of range");
    end

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic       ptr;
    logic       pin_cs;
    logic       pin_sck;
    logic       pin_mosi;
    logic       req0;
    logic       req1;
    logic       rel0;
    logic       rel1;
    logic       tmo_hit;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic [1:0]  req_mask;
    logic        in_grant;

    assign in_grant = (state == GRANT0) || (state == GRANT1);
    assign tmo_hit  = in_grant && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign req0     = bus.m0_req & ~req_mask[0];
    assign req1     = bus.m1_req & ~req_mask[1];

    // A timed-out master stays masked until its request is seen low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt  <= '0;
            req_mask <= '0;
            timeout  <= 1'b0;
        end else begin
            tmo_cnt <= in_grant ? tmo_cnt + 16'd1 : 16'd0;
            timeout <= tmo_hit;
            if (tmo_hit && state == GRANT0) req_mask[0] <= 1'b1;
            else if (!bus.m0_req)           req_mask[0] <= 1'b0;
            if (tmo_hit && state == GRANT1) req_mask[1] <= 1'b1;
            else if (!bus.m1_req)           req_mask[1] <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign req0    = bus.m0_req;
    assign req1    = bus.m1_req;
    assign timeout = 1'b0;
`endif

    assign rel0 = (!bus.m0_req && bus.m0_cs) || tmo_hit;
    assign rel1 = (!bus.m1_req && bus.m1_cs) || tmo_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAKE_CMD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAKE_CMD:  if (cnt == 8'd15) state_nxt = WAKE_WAIT;
            WAKE_WAIT: if (cnt == 8'(WAKE_CYCLES - 1)) state_nxt = IDLE;
            IDLE: begin
                if (req0 && (!req1 || !ptr)) state_nxt = GRANT0;
                else if (req1)               state_nxt = GRANT1;
            end
            GRANT0:    if (rel0) state_nxt = GAP;
            GRANT1:    if (rel1) state_nxt = GAP;
            GAP:       if (cnt == 8'(CS_GAP - 1)) state_nxt = IDLE;
            default:   state_nxt = WAKE_CMD;
        endcase
    end

    // Pin registers carry the wake command; they sit at the idle level otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            ptr      <= 1'b0;
            ready    <= 1'b0;
            pin_cs   <= 1'b1;
            pin_sck  <= 1'b0;
            pin_mosi <= 1'b0;
        end else begin
            if (state_nxt != state) cnt <= '0;
            else if (state == WAKE_CMD || state == WAKE_WAIT || state == GAP) cnt <= cnt + 8'd1;
            else cnt <= '0;

            if (state == WAKE_CMD) begin
                pin_cs   <= 1'b0;
                pin_sck  <= cnt[0];
                pin_mosi <= WAKE_OPCODE[3'd7 - cnt[3:1]];
            end else begin
                pin_cs   <= 1'b1;
                pin_sck  <= 1'b0;
                pin_mosi <= 1'b0;
            end

            if (state == WAKE_WAIT && state_nxt == IDLE) ready <= 1'b1;
            if (state == GRANT0 && rel0) ptr <= 1'b1;
            if (state == GRANT1 && rel1) ptr <= 1'b0;
        end
    end

    assign bus.m0_gnt = (state == GRANT0);
    assign bus.m1_gnt = (state == GRANT1);
    assign bus.m_miso = bus.spi_miso;

    always_comb begin
        bus.spi_cs   = pin_cs;
        bus.spi_sck  = pin_sck;
        bus.spi_mosi = pin_mosi;
        if (state == GRANT0) begin
            bus.spi_cs   = bus.m0_cs;
            bus.spi_sck  = bus.m0_sck;
            bus.spi_mosi = bus.m0_mosi;
        end else if (state == GRANT1) begin
            bus.spi_cs   = bus.m1_cs;
            bus.spi_sck  = bus.m1_sck;
            bus.spi_mosi = bus.m1_mosi;
        end
    end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: wake sequence, pass-through, round-robin order,
// held release, asynchronous reset mid-grant and (with the macro) the watchdog.
`timescale 1ns/1ps
module tb_spi_flash_arbiter;
  localparam int WAKE_CYCLES    = 40;
  localparam int CS_GAP         = 2;
  localparam int TIMEOUT_CYCLES = 100;

  logic clk = 1'b0;
  logic reset_n;
  logic ready;
  logic timeout;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_q[$];
  int   who;
  int   gap;
  int   held;
  int   pre;

  always #42 clk = ~clk;

  spi_flash_arbiter_if bus ();

  spi_flash_arbiter #(
    .WAKE_CYCLES(WAKE_CYCLES),
    .CS_GAP(CS_GAP),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .ready(ready),
    .timeout(timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_masters();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    bus.m0_cs = 1'b1;  bus.m1_cs = 1'b1;
    bus.m0_sck = 1'b0; bus.m1_sck = 1'b0;
    bus.m0_mosi = 1'b0; bus.m1_mosi = 1'b0;
    bus.spi_miso = 1'b0;
  endtask

  // Drive master m; the other master toggles inverted pins that must be ignored.
  task automatic set_pins(input int m, input logic cs, input logic sck, input logic mosi);
    if (m == 0) begin
      bus.m0_cs = cs; bus.m0_sck = sck; bus.m0_mosi = mosi;
      bus.m1_sck = ~sck; bus.m1_mosi = ~mosi;
    end else begin
      bus.m1_cs = cs; bus.m1_sck = sck; bus.m1_mosi = mosi;
      bus.m0_sck = ~sck; bus.m0_mosi = ~mosi;
    end
  endtask

  task automatic wake_seq(input logic hold_m0);
    int cyc = 0;
    int cs_low = 0;
    int early = 0;
    logic prev_sck = 1'b0;
    logic [7:0] op;
    op = 8'hAB;
    exp_q.delete();
    for (int b = 7; b >= 0; b--) exp_q.push_back(int'(op[b]));
    bus.m0_req = hold_m0;
    @(negedge clk);
    reset_n = 1'b1;
    while (!ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!bus.spi_cs) cs_low++;
      if (bus.spi_sck && !prev_sck && !bus.spi_cs)
        check_eq("wake_mosi", 32'(bus.spi_mosi), exp_q.size() > 0 ? exp_q.pop_front() : 2);
      prev_sck = bus.spi_sck;
      if (bus.m0_gnt || bus.m1_gnt) early++;
    end
    check_eq("ready_latency", cyc, 16 + WAKE_CYCLES);
    check_eq("wake_cs_low_cycles", cs_low, 16);
    check_eq("wake_bits_left", exp_q.size(), 0);
    check_eq("gnt_before_ready", early, 0);
  endtask

  task automatic wait_gnt(output int w, output int g);
    int n = 0;
    w = -1;
    g = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.m0_gnt) begin w = 0; break; end
      if (bus.m1_gnt) begin w = 1; break; end
      if (bus.spi_cs) g++;
    end
    if (w < 0) check_eq("wait_gnt_expired", n, 0);
  endtask

  task automatic xfer(input int m, input int nbytes);
    logic [7:0] d;
    int bad = 0;
    @(negedge clk);
    set_pins(m, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      d = 8'($urandom);
      for (int b = 7; b >= 0; b--) begin
        @(negedge clk);
        set_pins(m, 1'b0, 1'b0, d[b]);
        @(negedge clk);
        set_pins(m, 1'b0, 1'b1, d[b]);
        bus.spi_miso = 1'($urandom_range(0, 1));
        #1;
        if (bus.spi_cs !== 1'b0 || bus.spi_sck !== 1'b1 || bus.spi_mosi !== d[b] ||
            bus.m_miso !== bus.spi_miso) bad++;
      end
    end
    @(negedge clk);
    set_pins(m, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_pins(m, 1'b1, 1'b0, 1'b0);
    bus.m0_sck = 1'b0; bus.m1_sck = 1'b0; bus.m0_mosi = 1'b0; bus.m1_mosi = 1'b0;
    check_eq($sformatf("xfer_m%0d_mirror", m), bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_masters();
    bus.m0_req = 1'b1;
    #100;
    check_eq("rst_spi_cs", bus.spi_cs, 1);
    check_eq("rst_spi_sck", bus.spi_sck, 0);
    check_eq("rst_spi_mosi", bus.spi_mosi, 0);
    check_eq("rst_gnts", {bus.m0_gnt, bus.m1_gnt}, 0);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_timeout", timeout, 0);

    // Wake with m0 requesting from reset; grant follows the first IDLE cycle.
    wake_seq(1'b1);
    @(negedge clk);
    check_eq("m0_gnt_after_ready", bus.m0_gnt, 1);
    xfer(0, 2);

    // Asynchronous reset while m0 holds cs low.
    @(negedge clk);
    set_pins(0, 1'b0, 1'b1, 1'b1);
    #1;
    check_eq("mirror_cs_before_rst", bus.spi_cs, 0);
    @(posedge clk);
    #20;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_spi_cs", bus.spi_cs, 1);
    check_eq("async_rst_spi_sck", bus.spi_sck, 0);
    check_eq("async_rst_spi_mosi", bus.spi_mosi, 0);
    check_eq("async_rst_m0_gnt", bus.m0_gnt, 0);
    check_eq("async_rst_ready", ready, 0);
    idle_masters();
    #30;
    wake_seq(1'b0);

    // Round-robin with both masters requesting.
    exp_q.delete();
    for (int r = 0; r < 4; r++) exp_q.push_back(r % 2);
    @(negedge clk);
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    pre = 0;
    for (int r = 0; r < 4; r++) begin
      wait_gnt(who, gap);
      check_eq("rr_order", who, exp_q.size() > 0 ? exp_q.pop_front() : 9);
      if (r > 0) check_eq("rr_cs_gap", gap + pre, CS_GAP + 1);
      if (who < 0) break;
      xfer(who, 4);
      @(negedge clk);
      if (who == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
      @(negedge clk);
      pre = bus.spi_cs ? 1 : 0;
      if (r < 2) begin
        if (who == 0) bus.m0_req = 1'b1; else bus.m1_req = 1'b1;
      end
    end
    check_eq("rr_grants_left", exp_q.size(), 0);

    // m1 drops req with cs low: grant holds until cs rises.
    repeat (4) @(negedge clk);
    bus.m1_req = 1'b1;
    wait_gnt(who, gap);
    check_eq("hold_first_gnt", who, 1);
    set_pins(1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.m1_req = 1'b0;
    bus.m0_req = 1'b1;
    held = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.m1_gnt && !bus.m0_gnt) held++;
    end
    check_eq("hold_while_cs_low", held, 5);
    set_pins(1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("hold_m1_released", bus.m1_gnt, 0);
    pre = bus.spi_cs ? 1 : 0;
    wait_gnt(who, gap);
    check_eq("hold_then_m0", who, 0);
    check_eq("hold_gap", gap + pre, CS_GAP + 1);

`ifdef SPI_ARB_TIMEOUT_EN
    // m0 keeps cs low forever; watchdog releases it after TIMEOUT_CYCLES grant cycles.
    set_pins(0, 1'b0, 1'b0, 1'b0);
    bus.m1_req = 1'b1;
    held = 1;
    while (bus.m0_gnt && held < 300) begin
      @(negedge clk);
      if (bus.m0_gnt) held++;
    end
    check_eq("tmo_grant_cycles", held, TIMEOUT_CYCLES);
    check_eq("tmo_pulse", timeout, 1);
    check_eq("tmo_spi_cs", bus.spi_cs, 1);
    @(negedge clk);
    check_eq("tmo_pulse_width", timeout, 0);
    wait_gnt(who, gap);
    check_eq("tmo_then_m1", who, 1);
    bus.m1_req = 1'b0;
    held = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.m0_gnt) held++;
    end
    check_eq("tmo_m0_masked", held, 0);
    bus.m0_req = 1'b0;
    set_pins(0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.m0_req = 1'b1;
    wait_gnt(who, gap);
    check_eq("tmo_m0_regranted", who, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
